// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and helpers for the pipeline hazard controller
package pipe_ctrl_pkg;

  typedef enum logic {RUN = 1'b0, MUL_BUSY = 1'b1} hz_state_t;

  // XZR reads as zero, so a write to it can never feed a later read
  localparam logic [4:0] XZR = 5'd31;

  // Pipeline-register controls driven every cycle
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_bubble;
    logic exmem_bubble;
    logic mul_busy;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_RUN = '{
    pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1,
    idex_bubble: 1'b0, exmem_bubble: 1'b0, mul_busy: 1'b0
  };

  // A load in EX whose destination is read by the instruction in ID
  function automatic logic load_use(
    input logic       ex_load,
    input logic [4:0] ex_rd,
    input logic       uses_rn,
    input logic [4:0] rn,
    input logic       uses_rm,
    input logic [4:0] rm
  );
    return ex_load && (ex_rd != XZR) &&
           ((uses_rn && (rn == ex_rd)) || (uses_rm && (rm == ex_rd)));
  endfunction

endpackage

// File: rtl/pipe_down_counter.sv
// rtl/pipe_down_counter.sv - loadable down counter with zero flag
module pipe_down_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load has priority over decrement; reset clears to zero
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use / branch / multiply hazard controller; optional PIPE_PERF_CNT_EN counters
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ID_Rn,
  input  logic [4:0] ID_Rm,
  input  logic       ID_usesRn,
  input  logic       ID_usesRm,
  input  logic       ID_BrTaken,
  input  logic [4:0] EX_Rd,
  input  logic       EX_read_enable,
  input  logic       EX_mul,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_en,
  output logic       idex_bubble,
  output logic       exmem_bubble,
  output logic       mul_busy,
  output logic       mul_done
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  localparam int CW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  // The EX_mul cycle and the cnt==0 cycle bracket the count, hence MUL_LAT-2
  localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LAT - 2);

  hz_state_t state, state_nxt;
  pipe_ctl_t ctl;
  logic      lu;
  logic      cnt_load;
  logic      cnt_dec;
  logic      cnt_zero;

  assign lu = load_use(EX_read_enable, EX_Rd, ID_usesRn, ID_Rn, ID_usesRm, ID_Rm);

  pipe_down_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (CNT_INIT),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and controls: reset > multiply freeze > load-use > taken branch
  always_comb begin
    ctl       = CTL_RUN;
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    mul_done  = 1'b0;
    if (reset) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN: begin
          if (EX_mul) begin
            ctl.pc_en        = 1'b0;
            ctl.ifid_en      = 1'b0;
            ctl.idex_en      = 1'b0;
            ctl.exmem_bubble = 1'b1;
            cnt_load         = 1'b1;
            state_nxt        = MUL_BUSY;
          end else if (lu) begin
            ctl.pc_en       = 1'b0;
            ctl.ifid_en     = 1'b0;
            ctl.idex_bubble = 1'b1;
          end else if (ID_BrTaken) begin
            ctl.ifid_flush = 1'b1;
          end
        end
        MUL_BUSY: begin
          ctl.pc_en        = 1'b0;
          ctl.ifid_en      = 1'b0;
          ctl.idex_en      = 1'b0;
          ctl.mul_busy     = 1'b1;
          ctl.exmem_bubble = 1'b1;
          if (cnt_zero) begin
            // Last multiply cycle: let the result advance into MEM
            ctl.exmem_bubble = 1'b0;
            mul_done         = 1'b1;
            state_nxt        = RUN;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign pc_en        = ctl.pc_en;
  assign ifid_en      = ctl.ifid_en;
  assign ifid_flush   = ctl.ifid_flush;
  assign idex_en      = ctl.idex_en;
  assign idex_bubble  = ctl.idex_bubble;
  assign exmem_bubble = ctl.exmem_bubble;
  assign mul_busy     = ctl.mul_busy;

`ifdef PIPE_PERF_CNT_EN
  // Stall and flush event counters, wrapping naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!ctl.pc_en) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
      if (ctl.ifid_flush) begin
        flush_count <= flush_count + 1'b1;
      end
    end
  end
`endif

endmodule
